// File: rtl/perf_counter_bank_pkg.sv
// perf_pkg: shared definitions for the performance counter bank.
//   perf_state_t   : bank state machine encoding (IDLE=0, RUN=1, FROZEN=2)
//   STATE_*        : raw encodings of the above, for software-visible decode
//   CH_*           : default channel map used by the processor integration
package perf_pkg;

   localparam logic [1:0] STATE_IDLE   = 2'd0;
   localparam logic [1:0] STATE_RUN    = 2'd1;
   localparam logic [1:0] STATE_FROZEN = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = STATE_IDLE,
      RUN    = STATE_RUN,
      FROZEN = STATE_FROZEN
   } perf_state_t;

   // Default channel map: retired instructions, ICache req/hit, DCache req/hit.
   localparam int unsigned CH_INST  = 0;
   localparam int unsigned CH_ICREQ = 1;
   localparam int unsigned CH_ICHIT = 2;
   localparam int unsigned CH_DCREQ = 3;
   localparam int unsigned CH_DCHIT = 4;

endpackage

// File: rtl/perf_counter_bank_counter.sv
// perf_counter: one event channel with a multi-bit increment and sticky overflow.
// Build option: PERF_COUNTER_SAT_EN selects saturating arithmetic (default wraps).
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   clr          : synchronous clear of count and overflow flag (wins over cnt_en)
//   cnt_en       : add inc this edge
//   inc          : per-cycle increment, zero-extended
//   cnt          : current count
//   ovf          : sticky overflow flag
module perf_counter #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned INC_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             cnt_en,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);

   logic [CNT_W:0] incExt;
   logic [CNT_W:0] sum;
   logic           carry;

   assign incExt = {{(CNT_W + 1 - INC_W){1'b0}}, inc};
   assign sum    = {1'b0, cnt} + incExt;
   assign carry  = sum[CNT_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ovf <= 1'b0;
      end else if (cnt_en) begin
`ifdef PERF_COUNTER_SAT_EN
         cnt <= carry ? '1 : sum[CNT_W-1:0];
`else
         cnt <= sum[CNT_W-1:0];
`endif
         if (carry) ovf <= 1'b1;
      end
   end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters plus a RUN-cycle counter, controlled
// by an IDLE/RUN/FROZEN state machine, with registered indexed readout.
// Build option: PERF_COUNTER_SAT_EN makes channel counters and cycle_count saturate.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   en           : start counting (IDLE only)
//   halt         : processor halt; last cycle is counted, then FROZEN
//   clr          : clear all counts/flags and return to IDLE (highest priority)
//   ev_inc       : per-channel increments, channel i at [i*INC_W +: INC_W]
//   rd_sel       : readout channel index (>= NUM_CH reads 0)
//   rd_data      : selected counter, one cycle latency, pre-update value
//   cycle_count  : cycles spent in RUN
//   ovf          : sticky per-channel overflow flags
//   state        : current state encoding
//   halted       : high while FROZEN
module perf_counter_bank
   import perf_pkg::*;
#(
   parameter int unsigned NUM_CH = 8,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned INC_W  = 2,
   parameter int unsigned SEL_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    halt,
   input  logic                    clr,
   input  logic [NUM_CH*INC_W-1:0] ev_inc,
   input  logic [SEL_W-1:0]        rd_sel,
   output logic [CNT_W-1:0]        rd_data,
   output logic [CNT_W-1:0]        cycle_count,
   output logic [NUM_CH-1:0]       ovf,
   output logic [1:0]              state,
   output logic                    halted
);

   perf_state_t      stateQ;
   perf_state_t      stateNext;
   logic             cntEn;
   logic [CNT_W-1:0] chCnt [NUM_CH];
   logic [CNT_W-1:0] rdMux;

   // ---------------- state machine ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) stateQ <= IDLE;
      else      stateQ <= stateNext;
   end

   always_comb begin
      stateNext = stateQ;
      if (clr) begin
         stateNext = IDLE;
      end else begin
         case (stateQ)
            IDLE:    if (en)   stateNext = RUN;
            RUN:     if (halt) stateNext = FROZEN;
            FROZEN:  stateNext = FROZEN;
            default: stateNext = IDLE;
         endcase
      end
   end

   // The halting cycle is still counted: counting depends only on being in RUN.
   assign cntEn  = (stateQ == RUN) && !clr;
   assign state  = stateQ;
   assign halted = (stateQ == FROZEN);

   // ---------------- channel counters ----------------
   for (genvar g = 0; g < NUM_CH; g++) begin : gCh
      perf_counter #(
         .CNT_W (CNT_W),
         .INC_W (INC_W)
      ) uCnt (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr),
         .cnt_en (cntEn),
         .inc    (ev_inc[g*INC_W +: INC_W]),
         .cnt    (chCnt[g]),
         .ovf    (ovf[g])
      );
   end

   // ---------------- cycle counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_count <= '0;
      end else if (clr) begin
         cycle_count <= '0;
      end else if (cntEn) begin
`ifdef PERF_COUNTER_SAT_EN
         if (cycle_count != '1) cycle_count <= cycle_count + 1'b1;
`else
         cycle_count <= cycle_count + 1'b1;
`endif
      end
   end

   // ---------------- readout ----------------
   // Compare-based mux so indices beyond NUM_CH fall through to zero.
   always_comb begin
      rdMux = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) rdMux = chCnt[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd_data <= '0;
      else      rd_data <= rdMux;
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
module tb_perf_counter_bank;

   localparam int unsigned NUM_CH = 5;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned INC_W  = 2;
   localparam int unsigned SEL_W  = 3;

   logic                    clk;
   logic                    rst;
   logic                    en;
   logic                    halt;
   logic                    clr;
   logic [NUM_CH*INC_W-1:0] ev_inc;
   logic [SEL_W-1:0]        rd_sel;
   logic [CNT_W-1:0]        rd_data;
   logic [CNT_W-1:0]        cycle_count;
   logic [NUM_CH-1:0]       ovf;
   logic [1:0]              state;
   logic                    halted;

   int testsRun    = 0;
   int testsFailed = 0;

`ifdef PERF_COUNTER_SAT_EN
   localparam logic [CNT_W-1:0] EXP_OVF_CNT  = 8'd255;
   localparam logic [CNT_W-1:0] EXP_OVF_CNT2 = 8'd255;
`else
   localparam logic [CNT_W-1:0] EXP_OVF_CNT  = 8'd1;
   localparam logic [CNT_W-1:0] EXP_OVF_CNT2 = 8'd2;
`endif

   perf_counter_bank #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .INC_W  (INC_W),
      .SEL_W  (SEL_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .halt        (halt),
      .clr         (clr),
      .ev_inc      (ev_inc),
      .rd_sel      (rd_sel),
      .rd_data     (rd_data),
      .cycle_count (cycle_count),
      .ovf         (ovf),
      .state       (state),
      .halted      (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b0;
      en     = 1'b0;
      halt   = 1'b0;
      clr    = 1'b0;
      ev_inc = '0;
      rd_sel = '0;
      repeat (2) tick();
      checkVal("rst_state", 32'(state), 0);
      checkVal("rst_cycle", 32'(cycle_count), 0);
      checkVal("rst_ovf", 32'(ovf), 0);
      checkVal("rst_rd", 32'(rd_data), 0);
      checkVal("rst_halted", 32'(halted), 0);
      rst = 1'b1;

      // Start, then ch0 +1 for 10 RUN cycles.
      en = 1'b1;
      tick();
      en     = 1'b0;
      ev_inc = 10'h001;
      rd_sel = 3'd0;
      checkVal("en_run", 32'(state), 1);
      repeat (10) tick();
      checkVal("run10_cycle", 32'(cycle_count), 10);
      checkVal("run10_rd_pre", 32'(rd_data), 9);
      ev_inc = '0;
      tick();
      checkVal("run10_rd", 32'(rd_data), 10);
      checkVal("run11_cycle", 32'(cycle_count), 11);

      // Halt with ch3 +3 on the same edge; then ignore everything in FROZEN.
      ev_inc = 10'h0C0;
      halt   = 1'b1;
      tick();
      halt   = 1'b0;
      ev_inc = '1;
      en     = 1'b1;
      checkVal("halt_state", 32'(state), 2);
      checkVal("halt_halted", 32'(halted), 1);
      checkVal("halt_cycle", 32'(cycle_count), 12);
      rd_sel = 3'd3;
      repeat (3) tick();
      en = 1'b0;
      checkVal("frz_ch3", 32'(rd_data), 3);
      checkVal("frz_cycle", 32'(cycle_count), 12);
      checkVal("frz_state", 32'(state), 2);

      // Clear from FROZEN; readout on the clear edge shows pre-clear value.
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checkVal("clr_rd_pre", 32'(rd_data), 3);
      checkVal("clr_state", 32'(state), 0);
      checkVal("clr_cycle", 32'(cycle_count), 0);
      checkVal("clr_halted", 32'(halted), 0);
      tick();
      checkVal("idle_rd", 32'(rd_data), 0);
      checkVal("idle_cycle", 32'(cycle_count), 0);

      // Overflow: ch1 +2 x127 = 254, then +3.
      en = 1'b1;
      tick();
      en     = 1'b0;
      rd_sel = 3'd1;
      ev_inc = 10'h008;
      repeat (127) tick();
      checkVal("pre_ovf_rd", 32'(rd_data), 252);
      checkVal("pre_ovf_cycle", 32'(cycle_count), 127);
      checkVal("pre_ovf_flag", 32'(ovf), 0);
      ev_inc = 10'h00C;
      tick();
      checkVal("ovf_flag", 32'(ovf), 32'h2);
      ev_inc = '0;
      tick();
      checkVal("ovf_cnt", 32'(rd_data), 32'(EXP_OVF_CNT));
      checkVal("ovf_cycle", 32'(cycle_count), 129);
      ev_inc = 10'h004;
      tick();
      ev_inc = '0;
      tick();
      checkVal("ovf_cnt2", 32'(rd_data), 32'(EXP_OVF_CNT2));
      checkVal("ovf_sticky", 32'(ovf), 32'h2);

      // clr + en + halt together in RUN: clear wins.
      clr    = 1'b1;
      en     = 1'b1;
      halt   = 1'b1;
      ev_inc = '1;
      tick();
      clr  = 1'b0;
      en   = 1'b0;
      halt = 1'b0;
      checkVal("clr_all_state", 32'(state), 0);
      checkVal("clr_all_cycle", 32'(cycle_count), 0);
      checkVal("clr_all_ovf", 32'(ovf), 0);
      checkVal("clr_all_halted", 32'(halted), 0);
      tick();
      checkVal("clr_all_rd", 32'(rd_data), 0);

      // Restart from 0 on ch4; then out-of-range select.
      en = 1'b1;
      tick();
      en     = 1'b0;
      rd_sel = 3'd4;
      ev_inc = 10'h100;
      repeat (2) tick();
      checkVal("ch4_rd_pre", 32'(rd_data), 1);
      checkVal("ch4_cycle", 32'(cycle_count), 2);
      ev_inc = '0;
      tick();
      checkVal("ch4_rd", 32'(rd_data), 2);
      rd_sel = 3'd7;
      tick();
      checkVal("sel7_rd", 32'(rd_data), 0);
      checkVal("sel7_state", 32'(state), 1);
      rd_sel = 3'd4;
      tick();
      checkVal("sel4_rd", 32'(rd_data), 2);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b0;
      en  = 1'b1;
      #1;
      checkVal("arst_state", 32'(state), 0);
      checkVal("arst_cycle", 32'(cycle_count), 0);
      checkVal("arst_rd", 32'(rd_data), 0);
      repeat (2) tick();
      checkVal("arst_en_ign", 32'(state), 0);
      en  = 1'b0;
      rst = 1'b1;
      tick();
      checkVal("arst_rel_state", 32'(state), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
